// File: rtl/fuzz_response_checker.sv
// fuzz_response_checker: checks a stream of DUT output words against a stream of
// golden expected words. It counts mismatches, records the index and XOR difference
// of the first failing vector, and reports a pass/fail verdict at the end of each run.
// Optional feature macro MISR_SIGNATURE_EN: when defined, a 32-bit MISR is folded
// over the sampled y words. When undefined, signature_o is tied to 32'hFFFF_FFFF.
module fuzz_response_checker #(
  parameter int WIDTH       = 336,
  parameter int NUM_VECTORS = 21,
  parameter int IDX_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             y_valid_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             exp_valid_i,
  input  logic [WIDTH-1:0] exp_data_i,
  output logic             exp_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [IDX_W-1:0] first_fail_idx_o,
  output logic [WIDTH-1:0] first_fail_xor_o,
  output logic [31:0]      signature_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ff_idx_q, ff_idx_d;
  logic [WIDTH-1:0]   ff_xor_q, ff_xor_d;
  logic               ff_seen_q, ff_seen_d;

  logic               compare_s;
  logic               last_s;
  logic               start_run_s;
  logic [WIDTH-1:0]   diff_s;
  logic               mismatch_s;

  // A compare needs both streams valid while running; only then is an expected word consumed.
  assign compare_s   = (state_q == ST_RUN) && y_valid_i && exp_valid_i;
  assign last_s      = compare_s && (idx_q == LAST_IDX);
  // A start is honoured only outside a run, so a pulse during RUN cannot clear the counters.
  assign start_run_s = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign diff_s      = y_i ^ exp_data_i;
  assign mismatch_s  = |diff_s;

  // State register for the run-control FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a start launches a run, and the final compare ends it (a start on that cycle is ignored).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
        else         state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_d = ST_DONE;
        else        state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start_i) state_d = ST_RUN;
        else         state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: status comes from registered state, and exp_ready mirrors the compare term.
  always_comb begin
    exp_ready_o      = compare_s;
    busy_o           = (state_q == ST_RUN);
    done_o           = (state_q == ST_DONE);
    pass_o           = (state_q == ST_DONE) && (cnt_q == {CNT_W{1'b0}});
    mismatch_cnt_o   = cnt_q;
    first_fail_idx_o = ff_idx_q;
    first_fail_xor_o = ff_xor_q;
  end

  // Compare datapath: clear on run entry, then count mismatches and capture only the first failure.
  always_comb begin
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ff_idx_d  = ff_idx_q;
    ff_xor_d  = ff_xor_q;
    ff_seen_d = ff_seen_q;
    if (start_run_s) begin
      idx_d     = {IDX_W{1'b0}};
      cnt_d     = {CNT_W{1'b0}};
      ff_idx_d  = {IDX_W{1'b0}};
      ff_xor_d  = {WIDTH{1'b0}};
      ff_seen_d = 1'b0;
    end else if (compare_s) begin
      idx_d = idx_q + IDX_W'(1);
      if (mismatch_s) begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        else                        cnt_d = cnt_q;
        if (!ff_seen_q) begin
          ff_idx_d  = idx_q;
          ff_xor_d  = diff_s;
          ff_seen_d = 1'b1;
        end else begin
          ff_idx_d  = ff_idx_q;
          ff_xor_d  = ff_xor_q;
          ff_seen_d = ff_seen_q;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= {IDX_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      ff_idx_q  <= {IDX_W{1'b0}};
      ff_xor_q  <= {WIDTH{1'b0}};
      ff_seen_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ff_idx_q  <= ff_idx_d;
      ff_xor_q  <= ff_xor_d;
      ff_seen_q <= ff_seen_d;
    end
  end

`ifdef MISR_SIGNATURE_EN
  localparam int NCHUNK = (WIDTH + 31) / 32;

  // XOR of all 32-bit chunks of v, with the top chunk zero-padded.
  function automatic logic [31:0] fold32(input logic [WIDTH-1:0] v);
    logic [NCHUNK*32-1:0] pad;
    logic [31:0]          acc;
    pad            = {(NCHUNK*32){1'b0}};
    pad[WIDTH-1:0] = v;
    acc            = 32'h0000_0000;
    for (int i = 0; i < NCHUNK; i++) begin
      acc = acc ^ pad[i*32 +: 32];
    end
    return acc;
  endfunction

  // One MISR step with polynomial x^32+x^22+x^2+x+1.
  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] fold);
    logic fb;
    fb = sig[31] ^ sig[21] ^ sig[1] ^ sig[0];
    return {sig[30:0], fb} ^ fold;
  endfunction

  logic [31:0] sig_q, sig_d;

  // Signature next state: reseed on run entry, fold y on every compare, hold otherwise (so it freezes in DONE).
  always_comb begin
    sig_d = sig_q;
    if (start_run_s) begin
      sig_d = 32'hFFFF_FFFF;
    end else if (compare_s) begin
      sig_d = misr_step(sig_q, fold32(y_i));
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 32'hFFFF_FFFF;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature_o = sig_q;
`else
  assign signature_o = 32'hFFFF_FFFF;
`endif

endmodule

// File: tb/tb_fuzz_response_checker.sv
// Self-checking bench for fuzz_response_checker: directed run scenarios plus a
// randomized phase, all scored against a run-level behavioural model.
module tb_fuzz_response_checker;
  localparam int W  = 336;
  localparam int NV = 21;
  localparam int IW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          y_valid_i;
  logic [W-1:0]  y_i;
  logic          exp_valid_i;
  logic [W-1:0]  exp_data_i;
  logic          exp_ready_o;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic [CW-1:0] mismatch_cnt_o;
  logic [IW-1:0] first_fail_idx_o;
  logic [W-1:0]  first_fail_xor_o;
  logic [31:0]   signature_o;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model of one run
  bit          m_run, m_done, m_seen;
  int          m_idx, m_cnt, m_ffi;
  logic [W-1:0] m_ffx;
  logic [31:0]  m_sig;
  int          ready_cnt;

  fuzz_response_checker #(.WIDTH(W), .NUM_VECTORS(NV), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .y_valid_i(y_valid_i), .y_i(y_i),
    .exp_valid_i(exp_valid_i), .exp_data_i(exp_data_i),
    .exp_ready_o(exp_ready_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .mismatch_cnt_o(mismatch_cnt_o), .first_fail_idx_o(first_fail_idx_o),
    .first_fail_xor_o(first_fail_xor_o), .signature_o(signature_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_sig(input logic [31:0] sig, input logic [W-1:0] y);
`ifdef MISR_SIGNATURE_EN
    logic [31:0] fold;
    logic        fb;
    fold = 32'h0;
    for (int b = 0; b < W; b++) fold[b % 32] = fold[b % 32] ^ y[b];
    fb = ^(sig & 32'h8020_0003);
    return ((sig << 1) | {31'h0, fb}) ^ fold;
`else
    return sig;
`endif
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < (W + 31) / 32; k++) w = (w << 32) | W'($urandom);
    return w;
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_seen = 0;
    m_idx = 0; m_cnt = 0; m_ffi = 0;
    m_ffx = '0; m_sig = 32'hFFFF_FFFF;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".busy"}, W'(busy_o), W'(m_run));
    chk({tag, ".done"}, W'(done_o), W'(m_done));
    chk({tag, ".pass"}, W'(pass_o), W'(m_done && (m_cnt == 0)));
    chk({tag, ".cnt"}, W'(mismatch_cnt_o), W'(m_cnt));
    chk({tag, ".ffi"}, W'(first_fail_idx_o), W'(m_ffi));
    chk({tag, ".ffx"}, first_fail_xor_o, m_ffx);
    chk({tag, ".sig"}, W'(signature_o), W'(m_sig));
  endtask

  // entered and left at posedge+1
  task automatic step(input string tag, input logic st, input logic yv, input logic [W-1:0] yd,
                      input logic ev, input logic [W-1:0] ed);
    logic [W-1:0] diff;
    start_i = st; y_valid_i = yv; y_i = yd; exp_valid_i = ev; exp_data_i = ed;
    #2;
    chk({tag, ".exp_ready"}, W'(exp_ready_o), W'(m_run && yv && ev));
    if (exp_ready_o === 1'b1) ready_cnt++;
    @(posedge clk);
    if (!m_run && st) begin
      m_run = 1; m_done = 0; m_seen = 0;
      m_idx = 0; m_cnt = 0; m_ffi = 0; m_ffx = '0; m_sig = 32'hFFFF_FFFF;
    end else if (m_run && yv && ev) begin
      diff = yd ^ ed;
      if (diff != '0) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (!m_seen) begin m_seen = 1; m_ffi = m_idx; m_ffx = diff; end
      end
      m_sig = model_sig(m_sig, yd);
      m_idx++;
      if (m_idx == NV) begin m_run = 0; m_done = 1; end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    start_i = 1'b0; y_valid_i = 1'b1; exp_valid_i = 1'b1;
    #2;
    model_reset();
    chk({tag, ".rst_ready"}, W'(exp_ready_o), W'(0));
    check_outputs({tag, ".rst_now"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    y_valid_i = 1'b0; exp_valid_i = 1'b0;
    check_outputs({tag, ".rst_after"});
  endtask

  logic [W-1:0] e, y, one;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; y_valid_i = 1'b0; y_i = '0; exp_valid_i = 1'b0; exp_data_i = '0;
    one = W'(1);
    ready_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs("reset");
    chk("reset.sig_const", W'(signature_o), W'(32'hFFFF_FFFF));
    rst_n = 1'b1;

    // 1: all-zero run
    step("s1.start", 1, 0, '0, 0, '0);
    ready_cnt = 0;
    for (int v = 0; v < NV; v++) step("s1", 0, 1, '0, 1, '0);
    chk("s1.done", W'(done_o), W'(1));
    chk("s1.pass", W'(pass_o), W'(1));
    chk("s1.ready_pulses", W'(ready_cnt), W'(NV));
    step("s1.idle", 0, 1, '0, 1, '0);

    // 2: mismatches at vectors 5 and 9, started from DONE
    step("s2.start", 1, 0, '0, 0, '0);
    for (int v = 0; v < NV; v++) begin
      e = rand_word();
      y = e;
      if (v == 5) y = e ^ (one << 100);
      if (v == 9) y = e ^ one;
      step("s2", 0, 1, y, 1, e);
    end
    chk("s2.cnt", W'(mismatch_cnt_o), W'(2));
    chk("s2.ffi", W'(first_fail_idx_o), W'(5));
    chk("s2.ffx", first_fail_xor_o, one << 100);
    chk("s2.pass", W'(pass_o), W'(0));

    // 3: throttled expected stream
    step("s3.start", 1, 0, '0, 0, '0);
    ready_cnt = 0;
    for (int c = 0; c < 100 && !done_o; c++) begin
      e = rand_word();
      step("s3", 0, 1, e, logic'(c % 2), e);
    end
    chk("s3.done", W'(done_o), W'(1));
    chk("s3.ready_pulses", W'(ready_cnt), W'(NV));

    // 4: reset after compare 10, then a fresh run
    step("s4.start", 1, 0, '0, 0, '0);
    for (int v = 0; v <= 10; v++) begin
      e = rand_word();
      step("s4a", 0, 1, e ^ W'(v % 3 == 0), 1, e);
    end
    do_reset("s4");
    step("s4.start2", 1, 0, '0, 0, '0);
    ready_cnt = 0;
    for (int v = 0; v < NV - 1; v++) step("s4b", 0, 1, one, 1, one);
    chk("s4.not_done", W'(done_o), W'(0));
    step("s4b.last", 0, 1, one, 1, one);
    chk("s4.done", W'(done_o), W'(1));
    chk("s4.ready_pulses", W'(ready_cnt), W'(NV));

    // 5: start pulses during RUN are ignored
    step("s5.start", 1, 0, '0, 0, '0);
    for (int v = 0; v < NV; v++) begin
      e = rand_word();
      step("s5", logic'(v == 3 || v == NV - 1), 1, (v == 1) ? ~e : e, 1, e);
    end
    chk("s5.cnt", W'(mismatch_cnt_o), W'(1));
    chk("s5.done", W'(done_o), W'(1));
    step("s5.restart", 1, 0, '0, 0, '0);
    chk("s5.restart_busy", W'(busy_o), W'(1));
    chk("s5.restart_cnt", W'(mismatch_cnt_o), W'(0));

    // 6: single compare with y=1 from the reset seed
    do_reset("s6");
    step("s6.start", 1, 0, '0, 0, '0);
    step("s6", 0, 1, one, 1, one);
    chk("s6.sig_const", W'(signature_o), W'(32'hFFFF_FFFF));
    for (int v = 1; v < NV; v++) begin
      e = rand_word();
      step("s6.fill", 0, 1, e, 1, e);
    end

    // 7: randomized traffic
    for (int c = 0; c < 600; c++) begin
      e = rand_word();
      y = ($urandom_range(0, 7) == 0) ? (e ^ (one << $urandom_range(0, W - 1))) : e;
      step("rnd", logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 3) != 0), y,
           logic'($urandom_range(0, 3) != 0), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
